// File: rtl/instr_encode_loader_if.sv
// Request and instruction-memory write bus of the boot-time program loader.
`timescale 1ns/1ps
interface instr_encode_loader_if #(
  parameter int ADDR_W = 8
) ();
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_kind;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [5:0]        in_funct;
  logic [15:0]       in_imm;
  logic [25:0]       in_target;
  logic              in_last;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   count;

  // Environment side: issues requests and acknowledges memory writes.
  modport master (
    output in_valid, in_kind, in_rs, in_rt, in_rd, in_funct, in_imm, in_target, in_last,
    output mem_ack,
    input  in_ready, mem_we, mem_addr, mem_wdata, done, err, count
  );

  // Loader side.
  modport slave (
    input  in_valid, in_kind, in_rs, in_rt, in_rd, in_funct, in_imm, in_target, in_last,
    input  mem_ack,
    output in_ready, mem_we, mem_addr, mem_wdata, done, err, count
  );
endinterface

// File: rtl/instr_encode_loader.sv
// Encodes symbolic MIPS instructions (R, lw, sw, beq, addi, bne, j) and writes
// them to consecutive instruction-memory words over a write/ack handshake.
`timescale 1ns/1ps
module instr_encode_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0,
  parameter int MAX_WORDS = 256
) (
  input logic                clk,
  input logic                reset,
  instr_encode_loader_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_ENC, S_WRITE, S_DONE} state_e;

  typedef enum logic [2:0] {
    K_R, K_LW, K_SW, K_BEQ, K_ADDI, K_BNE, K_J, K_RSVD
  } kind_e;

  typedef struct packed {
    kind_e       kind;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
    logic        last;
  } req_t;

  localparam logic [ADDR_W:0] MAX_C = (ADDR_W+1)'(MAX_WORDS);
  localparam logic [ADDR_W:0] ONE_C = (ADDR_W+1)'(1);

  function automatic logic [31:0] encode(input req_t r);
    logic [31:0] w;
    w = 32'h0;
    case (r.kind)
      K_R:     w = {6'b000000, r.rs, r.rt, r.rd, 5'b00000, r.funct};
      K_LW:    w = {6'b100011, r.rs, r.rt, r.imm};
      K_SW:    w = {6'b101011, r.rs, r.rt, r.imm};
      K_BEQ:   w = {6'b000100, r.rs, r.rt, r.imm};
      K_ADDI:  w = {6'b001000, r.rs, r.rt, r.imm};
      K_BNE:   w = {6'b000101, r.rs, r.rt, r.imm};
      K_J:     w = {6'b000010, r.target};
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  state_e          state_q, state_d;
  req_t            req_q, req_d;
  logic [31:0]     word_q, word_d;
  logic [ADDR_W:0] count_q, count_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    word_d  = word_q;
    count_d = count_q;
    done_d  = done_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          req_d = '{kind:   kind_e'(bus.in_kind),
                    rs:     bus.in_rs,
                    rt:     bus.in_rt,
                    rd:     bus.in_rd,
                    funct:  bus.in_funct,
                    imm:    bus.in_imm,
                    target: bus.in_target,
                    last:   bus.in_last};
          state_d = S_ENC;
        end
      end
      S_ENC: begin
        // A reserved kind never reaches memory and never completes the load.
        if (req_q.kind == K_RSVD) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          word_d  = encode(req_q);
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (bus.mem_ack) begin
          count_d = count_q + ONE_C;
          if (req_q.last || (count_d == MAX_C)) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_DONE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      word_q  <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      word_q  <= word_d;
      count_q <= count_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE) && !reset;
  assign bus.mem_we    = (state_q == S_WRITE);
  assign bus.mem_addr  = ADDR_W'(BASE_ADDR) + count_q[ADDR_W-1:0];
  assign bus.mem_wdata = word_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.count     = count_q;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Scoreboard bench for instr_encode_loader: directed requests push expected
// memory writes; a monitor compares every presented write against the queue.
`timescale 1ns/1ps
module tb_instr_encode_loader;

  localparam int ADDR_W = 8;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } exp_t;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;
  int   n_writes;
  logic [ADDR_W-1:0] next_addr;
  exp_t exp_q[$];

  instr_encode_loader_if #(.ADDR_W(ADDR_W)) bus ();

  instr_encode_loader #(
    .ADDR_W(ADDR_W),
    .BASE_ADDR(0),
    .MAX_WORDS(256)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compares every presented write (stable or acked) with the queue head.
  always begin
    @(negedge clk);
    #1;
    if (!reset && bus.mem_we) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with empty scoreboard",
                 bus.mem_addr, bus.mem_wdata);
      end else begin
        check("sb_addr", 32'(bus.mem_addr), 32'(exp_q[0].addr));
        check("sb_data", bus.mem_wdata, exp_q[0].data);
        if (bus.mem_ack) begin
          void'(exp_q.pop_front());
          n_writes++;
        end
      end
    end
  end

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.in_kind   = 3'd0;
    bus.in_rs     = 5'd0;
    bus.in_rt     = 5'd0;
    bus.in_rd     = 5'd0;
    bus.in_funct  = 6'd0;
    bus.in_imm    = 16'd0;
    bus.in_target = 26'd0;
    bus.in_last   = 1'b0;
  endtask

  // Waits for in_ready, presents one request, returns on the negedge after acceptance.
  task automatic issue(input logic [2:0] kind, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [5:0] funct, input logic [15:0] imm,
                       input logic [25:0] target, input logic last, input logic [31:0] exp_data,
                       input logic ack_early);
    exp_t e;
    bit   rdy;
    rdy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        rdy = 1'b1;
        break;
      end
    end
    check("ready_wait", 32'(rdy), 32'd1);
    if (kind != 3'd7) begin
      e.addr = next_addr;
      e.data = exp_data;
      exp_q.push_back(e);
      next_addr++;
    end
    bus.in_valid  = 1'b1;
    bus.in_kind   = kind;
    bus.in_rs     = rs;
    bus.in_rt     = rt;
    bus.in_rd     = rd;
    bus.in_funct  = funct;
    bus.in_imm    = imm;
    bus.in_target = target;
    bus.in_last   = last;
    bus.mem_ack   = ack_early;
    @(negedge clk);
    idle_inputs();
    check("enc_no_ready", 32'(bus.in_ready), 32'd0);
    check("enc_no_we", 32'(bus.mem_we), 32'd0);
  endtask

  // Expects mem_we in the next cycle, holds ack low ack_delay cycles, then acks once.
  task automatic finish_write(input int ack_delay, input logic [ADDR_W:0] exp_count);
    @(negedge clk);
    check("we_at_k2", 32'(bus.mem_we), 32'd1);
    for (int i = 0; i < ack_delay; i++) begin
      bus.mem_ack = 1'b0;
      @(negedge clk);
      check("we_held", 32'(bus.mem_we), 32'd1);
    end
    bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    check("we_drop", 32'(bus.mem_we), 32'd0);
    check("count", 32'(bus.count), 32'(exp_count));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_ready_low", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    next_addr = '0;
    @(negedge clk);
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    n_writes  = 0;
    next_addr = '0;
    reset     = 1'b1;
    bus.mem_ack = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    check("rst_ready_low", 32'(bus.in_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(bus.in_ready), 32'd1);
    check("rst_we", 32'(bus.mem_we), 32'd0);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_wdata", bus.mem_wdata, 32'd0);

    // R-type add $3,$1,$2
    issue(3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'hAAAA, 26'h3FFFFFF, 1'b0, 32'h00221820, 1'b0);
    finish_write(0, 9'd1);
    // lw with junk in unused fields, ack already high during ENC
    issue(3'd1, 5'd0, 5'd8, 5'd31, 6'h3F, 16'h0004, 26'h1234567, 1'b0, 32'h8C080004, 1'b1);
    check("ack_in_enc_ignored", 32'(bus.count), 32'd1);
    finish_write(0, 9'd2);
    // j 0x10
    issue(3'd6, 5'd7, 5'd9, 5'd11, 6'h01, 16'hBEEF, 26'h0000010, 1'b0, 32'h08000010, 1'b0);
    finish_write(0, 9'd3);
    // beq with 3-cycle ack delay; monitor checks stability each cycle
    issue(3'd3, 5'd1, 5'd2, 5'd0, 6'h00, 16'hFFFF, 26'h0, 1'b0, 32'h1022FFFF, 1'b0);
    finish_write(3, 9'd4);
    // addi and bne
    issue(3'd4, 5'd3, 5'd4, 5'd0, 6'h00, 16'h1234, 26'h0, 1'b0, 32'h20641234, 1'b0);
    finish_write(1, 9'd5);
    issue(3'd5, 5'd5, 5'd6, 5'd0, 6'h00, 16'h8000, 26'h0, 1'b0, 32'h14A68000, 1'b0);
    finish_write(0, 9'd6);

    // Reserved kind with last=1: err, no write, no done
    issue(3'd7, 5'd1, 5'd1, 5'd1, 6'h01, 16'h0001, 26'h1, 1'b1, 32'h0, 1'b0);
    @(negedge clk);
    check("rsvd_err", 32'(bus.err), 32'd1);
    check("rsvd_ready", 32'(bus.in_ready), 32'd1);
    check("rsvd_no_done", 32'(bus.done), 32'd0);
    check("rsvd_count", 32'(bus.count), 32'd6);

    // sw $31,0($29) as last word
    issue(3'd2, 5'd29, 5'd31, 5'd0, 6'h00, 16'h0000, 26'h0, 1'b1, 32'hAFBF0000, 1'b0);
    finish_write(0, 9'd7);
    check("done_set", 32'(bus.done), 32'd1);
    check("err_sticky", 32'(bus.err), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_kind  = 3'd0;
    bus.mem_ack  = 1'b1;
    repeat (4) @(negedge clk);
    check("done_ready_low", 32'(bus.in_ready), 32'd0);
    check("done_no_we", 32'(bus.mem_we), 32'd0);
    check("done_count", 32'(bus.count), 32'd7);
    idle_inputs();
    bus.mem_ack = 1'b0;

    // Reset mid-WRITE discards the pending word
    do_reset();
    check("rst2_done", 32'(bus.done), 32'd0);
    check("rst2_err", 32'(bus.err), 32'd0);
    issue(3'd0, 5'd4, 5'd5, 5'd6, 6'h22, 16'h0, 26'h0, 1'b0, 32'h00853022, 1'b0);
    @(negedge clk);
    check("mid_we", 32'(bus.mem_we), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_we", 32'(bus.mem_we), 32'd0);
    check("mid_rst_count", 32'(bus.count), 32'd0);
    reset = 1'b0;
    exp_q.delete();
    next_addr = '0;
    issue(3'd4, 5'd0, 5'd2, 5'd0, 6'h00, 16'h0007, 26'h0, 1'b0, 32'h20020007, 1'b0);
    finish_write(0, 9'd1);

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    check("writes_seen", 32'(n_writes), 32'd8);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
